// File: rtl/pool1_pkg.sv
// pool1_pkg
// Shared constants and types for the pool1 window reader.
//   DW            sample width (two's complement)
//   IN_W / IN_H   pooled feature map geometry
//   K             window side; OUT_W window positions per axis
//   NUM_TAPS      taps per window
//   FRAME_SAMPLES samples captured per frame
//   BEATS         output beats per frame
// Types: addr_t (7-bit buffer address), cnt_t (loop counter), state_t.
package pool1_pkg;

  localparam int DW            = 12;
  localparam int IN_W          = 10;
  localparam int IN_H          = 10;
  localparam int K             = 5;
  localparam int OUT_W         = IN_W - K + 1;
  localparam int NUM_TAPS      = K * K;
  localparam int FRAME_SAMPLES = IN_W * IN_H;
  localparam int BEATS         = OUT_W * OUT_W * NUM_TAPS;
  localparam int AW            = 7;

  typedef logic [AW-1:0] addr_t;
  typedef logic [2:0]    cnt_t;

  typedef enum logic {
    CAPTURE,
    READ
  } state_t;

  // Row-major buffer address of a window tap.
  function automatic addr_t tap_addr(input cnt_t win_row, input cnt_t win_col,
                                     input cnt_t tap_r, input cnt_t tap_c);
    addr_t row;
    row = addr_t'(win_row) + addr_t'(tap_r);
    return addr_t'(row * addr_t'(IN_W)) + addr_t'(win_col) + addr_t'(tap_c);
  endfunction

endpackage

// File: rtl/pool1_win_addr_gen.sv
// pool1_win_addr_gen
// Walks the window read-out loop nest (win_row, win_col, tap_r, tap_c,
// outermost first) and presents the buffer address of the current tap.
// Ports:
//   cnn_clk, rst_n  clock / async active-low reset
//   advance         step to the next tap (wraps to all-zero after the last)
//   addr            buffer address of the current tap
//   first           current tap is (0,0) of its window
//   last            current tap is (K-1,K-1) of its window
//   final_beat      current tap is the last tap of the last window
module pool1_win_addr_gen
  import pool1_pkg::*;
(
  input  logic  cnn_clk,
  input  logic  rst_n,
  input  logic  advance,
  output addr_t addr,
  output logic  first,
  output logic  last,
  output logic  final_beat
);

  cnt_t win_row, win_col, tap_r, tap_c;

  logic tap_c_wrap, tap_r_wrap, win_col_wrap;

  assign tap_c_wrap   = (tap_c == cnt_t'(K - 1));
  assign tap_r_wrap   = (tap_r == cnt_t'(K - 1));
  assign win_col_wrap = (win_col == cnt_t'(OUT_W - 1));

  // Odometer: each counter steps only when every inner counter wraps. After
  // the final tap all four wrap together, so the next frame starts at zero
  // without an explicit clear.
  always_ff @(posedge cnn_clk or negedge rst_n) begin
    if (!rst_n) begin
      win_row <= '0;
      win_col <= '0;
      tap_r   <= '0;
      tap_c   <= '0;
    end else if (advance) begin
      if (tap_c_wrap) begin
        tap_c <= '0;
        if (tap_r_wrap) begin
          tap_r <= '0;
          if (win_col_wrap) begin
            win_col <= '0;
            if (win_row == cnt_t'(OUT_W - 1)) begin
              win_row <= '0;
            end else begin
              win_row <= win_row + cnt_t'(1);
            end
          end else begin
            win_col <= win_col + cnt_t'(1);
          end
        end else begin
          tap_r <= tap_r + cnt_t'(1);
        end
      end else begin
        tap_c <= tap_c + cnt_t'(1);
      end
    end
  end

  assign addr       = tap_addr(win_row, win_col, tap_r, tap_c);
  assign first      = (tap_r == '0) && (tap_c == '0);
  assign last       = tap_r_wrap && tap_c_wrap;
  assign final_beat = last && win_col_wrap && (win_row == cnt_t'(OUT_W - 1));

endmodule

// File: rtl/pool1_window_reader.sv
// pool1_window_reader
// Captures one pooled 10x10 feature map from the pooling stage, then replays
// it as 6x6 positions of 5x5 windows (900 beats) over a valid/ready stream,
// then re-arms for the next frame.
// Build option: POOL1_RELU_EN -- when defined, negative samples are stored
// as 0 at capture time; otherwise samples are stored bit-exact.
// Ports:
//   cnn_clk, rst_n  clock / async active-low reset
//   buffer_en, max  sample strobe and pooled sample from the pooling stage
//   out_ready       downstream accepts the current beat
//   out_valid       out_data holds a window tap
//   out_data        tap value
//   out_first       tap (0,0) of a window
//   out_last        tap (K-1,K-1) of a window
//   frame_done      one-cycle pulse after the final beat is accepted
//   busy            frame is being read out
//   drop_err        sticky: a sample arrived while reading out
module pool1_window_reader
  import pool1_pkg::*;
(
  input  logic          cnn_clk,
  input  logic          rst_n,
  input  logic          buffer_en,
  input  logic [DW-1:0] max,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_first,
  output logic          out_last,
  output logic          frame_done,
  output logic          busy,
  output logic          drop_err
);

  state_t        state_q, state_d;
  addr_t         cap_count;
  logic [DW-1:0] buffer [FRAME_SAMPLES];
  logic [DW-1:0] store_val;

  logic  capture_we, capture_last;
  logic  load, xfer, final_xfer;
  logic  issued_all, out_final;
  addr_t gen_addr;
  logic  gen_first, gen_last, gen_final;

  assign capture_we   = (state_q == CAPTURE) && buffer_en;
  assign capture_last = capture_we && (cap_count == addr_t'(FRAME_SAMPLES - 1));

  // The output register refills whenever it is empty or being drained, so a
  // continuously ready consumer sees one beat per cycle.
  assign load       = (state_q == READ) && !issued_all && (!out_valid || out_ready);
  assign xfer       = out_valid && out_ready;
  assign final_xfer = xfer && out_final;
  assign busy       = (state_q == READ);

`ifdef POOL1_RELU_EN
  assign store_val = max[DW-1] ? '0 : max;
`else
  assign store_val = max;
`endif

  pool1_win_addr_gen u_addr_gen (
    .cnn_clk    (cnn_clk),
    .rst_n      (rst_n),
    .advance    (load),
    .addr       (gen_addr),
    .first      (gen_first),
    .last       (gen_last),
    .final_beat (gen_final)
  );

  always_ff @(posedge cnn_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CAPTURE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CAPTURE: if (capture_last) state_d = READ;
      READ:    if (final_xfer)   state_d = CAPTURE;
      default: state_d = CAPTURE;
    endcase
  end

  // Sample storage has no reset; a frame is always fully rewritten before
  // it is read.
  always_ff @(posedge cnn_clk) begin
    if (capture_we) begin
      buffer[cap_count] <= store_val;
    end
  end

  always_ff @(posedge cnn_clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_count <= '0;
    end else if (capture_last) begin
      cap_count <= '0;
    end else if (capture_we) begin
      cap_count <= cap_count + addr_t'(1);
    end
  end

  // Marks that the last tap has been fetched so the wrapped address
  // generator is not re-read before the frame ends.
  always_ff @(posedge cnn_clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_all <= 1'b0;
    end else if (state_q == CAPTURE) begin
      issued_all <= 1'b0;
    end else if (load && gen_final) begin
      issued_all <= 1'b1;
    end
  end

  // Output register doubles as the registered buffer read; it holds its
  // contents through a stall because load requires out_ready.
  always_ff @(posedge cnn_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
      out_final  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= final_xfer;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= buffer[gen_addr];
        out_first <= gen_first;
        out_last  <= gen_last;
        out_final <= gen_final;
      end else if (xfer) begin
        out_valid <= 1'b0;
        out_first <= 1'b0;
        out_last  <= 1'b0;
        out_final <= 1'b0;
      end
    end
  end

  always_ff @(posedge cnn_clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_err <= 1'b0;
    end else if ((state_q == READ) && buffer_en) begin
      drop_err <= 1'b1;
    end
  end

endmodule
